// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants: FK, S-box, CK table, state encoding and helpers.
package sm4_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned KEY_W    = 128;
   localparam int unsigned N_ROUNDS = 32;
   localparam int unsigned IDX_W    = 5;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_READY,
      ST_STREAM
   } state_e;

   localparam logic [WORD_W-1:0] FK [4] = '{
      32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
   };

   localparam logic [KEY_W-1:0] FK_WORDS = {FK[0], FK[1], FK[2], FK[3]};

   localparam logic [7:0] SBOX [256] = '{
      8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
      8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
      8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
      8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
      8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
      8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
      8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
      8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
      8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
      8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
      8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
      8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
      8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
      8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
   };

   // CK_i byte j = (4i+j)*7 mod 256, precomputed so no multiplier is built.
   localparam logic [WORD_W-1:0] CK [N_ROUNDS] = '{
      32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
      32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
      32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
      32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
      32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
      32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
      32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
      32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
   };

   function automatic logic [WORD_W-1:0] ck_word(input logic [IDX_W-1:0] i);
      return CK[i];
   endfunction

   function automatic logic [WORD_W-1:0] rot_l32(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x << n) | (x >> (WORD_W - n));
   endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One SM4 key-expansion round: rk = k0 ^ T'(k1 ^ k2 ^ k3 ^ ck). Purely combinational.
module sm4_key_round
   import sm4_pkg::*;
(
   input  logic [WORD_W-1:0] k0_i,
   input  logic [WORD_W-1:0] k1_i,
   input  logic [WORD_W-1:0] k2_i,
   input  logic [WORD_W-1:0] k3_i,
   input  logic [WORD_W-1:0] ck_i,
   output logic [WORD_W-1:0] rk_c_o
);

   logic [WORD_W-1:0] mix_c;
   logic [WORD_W-1:0] sub_c;

   always_comb begin
      mix_c  = k1_i ^ k2_i ^ k3_i ^ ck_i;
      sub_c  = {SBOX[mix_c[31:24]], SBOX[mix_c[23:16]], SBOX[mix_c[15:8]], SBOX[mix_c[7:0]]};
      rk_c_o = k0_i ^ sub_c ^ rot_l32(sub_c, 13) ^ rot_l32(sub_c, 23);
   end

endmodule

// File: rtl/sm4_key_schedule.sv
// Sequential SM4 key schedule: expands one round per clock into a 32-word store,
// then streams the round keys forward or in reverse on request.
module sm4_key_schedule
   import sm4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [KEY_W-1:0]  mkey,
   output logic              sched_done,
   input  logic              rk_req,
   input  logic              rk_dir,
   output logic              rk_valid,
   output logic [IDX_W-1:0]  rk_idx,
   output logic [WORD_W-1:0] rk
);

   state_e             state_q;
   logic [KEY_W-1:0]   k_q;
   logic [IDX_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   ptr_q;
   logic               dir_q;
   logic               fin_q;
   logic               key_ready_q;
   logic               sched_done_q;
   logic               rk_valid_q;
   logic [IDX_W-1:0]   rk_idx_q;
   logic [WORD_W-1:0]  rk_q;
   logic [WORD_W-1:0]  store_q [N_ROUNDS];

   logic [WORD_W-1:0]  rk_d;
   logic               key_acc_c;

   // key_ready_q is only ever high in IDLE/READY, so it gates acceptance directly.
   assign key_acc_c = key_valid && key_ready_q;

   sm4_key_round u_round (
      .k0_i   (k_q[127:96]),
      .k1_i   (k_q[95:64]),
      .k2_i   (k_q[63:32]),
      .k3_i   (k_q[31:0]),
      .ck_i   (ck_word(cnt_q)),
      .rk_c_o (rk_d)
   );

   always_ff @(posedge clk or posedge rst) begin : fsm
      if (rst) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         cnt_q        <= '0;
         ptr_q        <= '0;
         dir_q        <= 1'b0;
         fin_q        <= 1'b0;
         key_ready_q  <= 1'b0;
         sched_done_q <= 1'b0;
         rk_valid_q   <= 1'b0;
         rk_idx_q     <= '0;
         rk_q         <= '0;
      end else begin
         rk_valid_q <= 1'b0;
         if (key_acc_c) begin
            k_q          <= mkey ^ FK_WORDS;
            cnt_q        <= '0;
            state_q      <= ST_EXPAND;
            key_ready_q  <= 1'b0;
            sched_done_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: key_ready_q <= 1'b1;
               ST_EXPAND: begin
                  k_q   <= {k_q[KEY_W-WORD_W-1:0], rk_d};
                  cnt_q <= cnt_q + IDX_W'(1);
                  if (cnt_q == LAST_IDX) begin
                     state_q      <= ST_READY;
                     sched_done_q <= 1'b1;
                     key_ready_q  <= 1'b1;
                  end
               end
               ST_READY: begin
                  if (rk_req) begin
                     dir_q       <= rk_dir;
                     ptr_q       <= rk_dir ? LAST_IDX : '0;
                     cnt_q       <= '0;
                     fin_q       <= 1'b0;
                     state_q     <= ST_STREAM;
                     key_ready_q <= 1'b0;
                  end
               end
               ST_STREAM: begin
                  // fin_q adds the single idle cycle after word 32 so the wrapped pointer is never emitted.
                  if (fin_q) begin
                     fin_q       <= 1'b0;
                     state_q     <= ST_READY;
                     key_ready_q <= 1'b1;
                  end else begin
                     rk_valid_q <= 1'b1;
                     rk_q       <= store_q[ptr_q];
                     rk_idx_q   <= ptr_q;
                     ptr_q      <= dir_q ? ptr_q - IDX_W'(1) : ptr_q + IDX_W'(1);
                     cnt_q      <= cnt_q + IDX_W'(1);
                     if (cnt_q == LAST_IDX) fin_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin : store_wr
      if (state_q == ST_EXPAND) store_q[cnt_q] <= rk_d;
   end

   assign key_ready  = key_ready_q;
   assign sched_done = sched_done_q;
   assign rk_valid   = rk_valid_q;
   assign rk_idx     = rk_idx_q;
   assign rk         = rk_q;

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Directed bench for sm4_key_schedule: standard vector, stream order, collisions, reset, back-to-back.
module tb_sm4_key_schedule;

   localparam logic [127:0] STD_KEY  = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   localparam logic [7:0] TB_SBOX [256] = '{
      8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
      8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
      8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
      8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
      8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
      8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
      8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
      8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
      8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
      8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
      8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
      8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
      8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
      8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
   };

   logic         clk;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] mkey;
   logic         sched_done;
   logic         rk_req;
   logic         rk_dir;
   logic         rk_valid;
   logic [4:0]   rk_idx;
   logic [31:0]  rk;

   int           n_cmp;
   int           n_fail;
   logic [31:0]  gold   [32];
   logic [31:0]  got_rk [64];
   logic [4:0]   got_idx[64];

   sm4_key_schedule dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .mkey       (mkey),
      .sched_done (sched_done),
      .rk_req     (rk_req),
      .rk_dir     (rk_dir),
      .rk_valid   (rk_valid),
      .rk_idx     (rk_idx),
      .rk         (rk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference key expansion written from the algorithm definition.
   task automatic compute_gold(input logic [127:0] mk);
      logic [31:0] fk [4];
      logic [31:0] kw [36];
      logic [31:0] ck, t, s;
      int          b;
      fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
      for (int j = 0; j < 4; j++) kw[j] = mk[127-32*j -: 32] ^ fk[j];
      for (int i = 0; i < 32; i++) begin
         ck = 32'h0;
         for (int j = 0; j < 4; j++) begin
            b  = ((4*i + j) * 7) % 256;
            ck = {ck[23:0], 8'(b)};
         end
         t = kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck;
         s = {TB_SBOX[t[31:24]], TB_SBOX[t[23:16]], TB_SBOX[t[15:8]], TB_SBOX[t[7:0]]};
         kw[i+4] = kw[i] ^ s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
         gold[i] = kw[i+4];
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      mkey      = k;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!sched_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Request one stream and capture up to 32 valid words over edges s+1..s+36.
   task automatic do_stream(input logic dir, input int kv_from,
                            output int nvalid, output int first_k, output int last_k, output int kr_bad);
      nvalid = 0; first_k = -1; last_k = -1; kr_bad = 0;
      @(negedge clk);
      rk_req = 1'b1;
      rk_dir = dir;
      @(posedge clk);
      @(negedge clk);
      rk_req = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k == kv_from) begin key_valid = 1'b1; mkey = ZERO_KEY; end
         if (k == kv_from + 5) key_valid = 1'b0;
         if (key_valid && key_ready !== 1'b0) kr_bad++;
         if (rk_valid === 1'b1) begin
            if (nvalid < 32) begin got_rk[nvalid] = rk; got_idx[nvalid] = rk_idx; end
            nvalid++;
            if (first_k < 0) first_k = k;
            last_k = k;
         end
      end
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      int seen;
      rst = 1'b1; key_valid = 1'b0; mkey = '0; rk_req = 1'b0; rk_dir = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_key_ready got %b want 0", key_ready); end
      n_cmp++; if (sched_done !== 1'b0) begin n_fail++; $display("FAIL reset_sched_done got %b want 0", sched_done); end
      n_cmp++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got %b want 0", rk_valid); end
      n_cmp++; if (rk !== 32'h0) begin n_fail++; $display("FAIL reset_rk got %h want 0", rk); end
      n_cmp++; if (rk_idx !== 5'd0) begin n_fail++; $display("FAIL reset_rk_idx got %0d want 0", rk_idx); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL idle_key_ready got %b want 1", key_ready); end
      seen = 0;
      rk_req = 1'b1;
      repeat (4) begin @(negedge clk); if (rk_valid !== 1'b0) seen++; end
      rk_req = 1'b0;
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL idle_rk_req_ignored got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_standard;
      int lat, nv, fk, lk, kb;
      compute_gold(STD_KEY);
      load_key(STD_KEY);
      n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL expand_key_ready got %b want 0", key_ready); end
      wait_done(lat);
      n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL std_done_latency got %0d want 32", lat); end
      n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL ready_key_ready got %b want 1", key_ready); end
      do_stream(1'b0, 0, nv, fk, lk, kb);
      n_cmp++; if (nv !== 32) begin n_fail++; $display("FAIL fwd_count got %0d want 32", nv); end
      n_cmp++; if (fk !== 1 || lk !== 32) begin n_fail++; $display("FAIL fwd_window got %0d..%0d want 1..32", fk, lk); end
      n_cmp++; if (got_idx[0] !== 5'd0 || got_rk[0] !== 32'hF12186F9) begin n_fail++; $display("FAIL fwd_rk0 got %0d/%h want 0/F12186F9", got_idx[0], got_rk[0]); end
      n_cmp++; if (got_idx[1] !== 5'd1 || got_rk[1] !== 32'h41662B61) begin n_fail++; $display("FAIL fwd_rk1 got %0d/%h want 1/41662B61", got_idx[1], got_rk[1]); end
      n_cmp++; if (got_idx[31] !== 5'd31 || got_rk[31] !== 32'h9124A012) begin n_fail++; $display("FAIL fwd_rk31 got %0d/%h want 31/9124A012", got_idx[31], got_rk[31]); end
      for (int j = 0; j < 32; j++) begin
         n_cmp++;
         if (got_idx[j] !== 5'(j) || got_rk[j] !== gold[j]) begin
            n_fail++; $display("FAIL fwd_word%0d got %0d/%h want %0d/%h", j, got_idx[j], got_rk[j], j, gold[j]);
         end
      end
      n_cmp++; if (sched_done !== 1'b1 || key_ready !== 1'b1) begin n_fail++; $display("FAIL after_fwd done/ready got %b/%b want 1/1", sched_done, key_ready); end
   endtask

   task automatic test_reverse;
      int nv, fk, lk, kb;
      do_stream(1'b1, 0, nv, fk, lk, kb);
      n_cmp++; if (nv !== 32) begin n_fail++; $display("FAIL rev_count got %0d want 32", nv); end
      n_cmp++; if (fk !== 1 || lk !== 32) begin n_fail++; $display("FAIL rev_window got %0d..%0d want 1..32", fk, lk); end
      n_cmp++; if (got_idx[0] !== 5'd31 || got_rk[0] !== 32'h9124A012) begin n_fail++; $display("FAIL rev_first got %0d/%h want 31/9124A012", got_idx[0], got_rk[0]); end
      n_cmp++; if (got_idx[31] !== 5'd0 || got_rk[31] !== 32'hF12186F9) begin n_fail++; $display("FAIL rev_last got %0d/%h want 0/F12186F9", got_idx[31], got_rk[31]); end
      for (int j = 0; j < 32; j++) begin
         n_cmp++;
         if (got_idx[j] !== 5'(31 - j) || got_rk[j] !== gold[31-j]) begin
            n_fail++; $display("FAIL rev_word%0d got %0d/%h want %0d/%h", j, got_idx[j], got_rk[j], 31 - j, gold[31-j]);
         end
      end
   endtask

   task automatic test_collision;
      int lat, seen;
      @(negedge clk);
      key_valid = 1'b1; mkey = STD_KEY; rk_req = 1'b1; rk_dir = 1'b0;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0; rk_req = 1'b0;
      n_cmp++; if (sched_done !== 1'b0 || key_ready !== 1'b0) begin n_fail++; $display("FAIL collide_accept done/ready got %b/%b want 0/0", sched_done, key_ready); end
      lat = 0; seen = 0;
      while (!sched_done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (rk_valid !== 1'b0) seen++;
      end
      repeat (3) begin @(negedge clk); if (rk_valid !== 1'b0) seen++; end
      n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL collide_latency got %0d want 32", lat); end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL collide_no_stream got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_midstream_key;
      int nv, fk, lk, kb, bad;
      do_stream(1'b0, 5, nv, fk, lk, kb);
      n_cmp++; if (kb !== 0) begin n_fail++; $display("FAIL midstream_key_ready got %0d high cycles want 0", kb); end
      n_cmp++; if (nv !== 32 || fk !== 1 || lk !== 32) begin n_fail++; $display("FAIL midstream_window got n=%0d %0d..%0d want 32 1..32", nv, fk, lk); end
      bad = 0;
      for (int j = 0; j < 32; j++) if (got_idx[j] !== 5'(j) || got_rk[j] !== gold[j]) bad++;
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL midstream_words got %0d wrong words want 0", bad); end
      bad = 0;
      repeat (4) begin @(negedge clk); if (sched_done !== 1'b1) bad++; end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL midstream_done_kept got %0d low cycles want 0", bad); end
   endtask

   task automatic test_reset_expand;
      int lat, nv, fk, lk, kb, bad;
      load_key(STD_KEY);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if ({key_ready, sched_done, rk_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_expand_flags got %b want 000", {key_ready, sched_done, rk_valid}); end
      n_cmp++; if (rk !== 32'h0 || rk_idx !== 5'd0) begin n_fail++; $display("FAIL rst_expand_data got %h/%0d want 0/0", rk, rk_idx); end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (6) begin @(negedge clk); if (rk_valid !== 1'b0 || sched_done !== 1'b0) bad++; end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_expand_quiet got %0d bad cycles want 0", bad); end
      load_key(STD_KEY);
      wait_done(lat);
      n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL rerun_latency got %0d want 32", lat); end
      do_stream(1'b0, 0, nv, fk, lk, kb);
      n_cmp++; if (nv !== 32 || got_rk[0] !== 32'hF12186F9 || got_rk[31] !== 32'h9124A012) begin
         n_fail++; $display("FAIL rerun_rk0_rk31 got n=%0d %h %h want 32 F12186F9 9124A012", nv, got_rk[0], got_rk[31]);
      end
   endtask

   task automatic test_back_to_back;
      int n, pat_bad;
      logic exp_v;
      n = 0; pat_bad = 0;
      @(negedge clk);
      rk_req = 1'b1; rk_dir = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rk_dir = 1'b1;
      for (int k = 1; k <= 75; k++) begin
         @(negedge clk);
         if (k == 34) rk_req = 1'b0;
         exp_v = (k >= 1 && k <= 32) || (k >= 35 && k <= 66);
         if (rk_valid !== exp_v) pat_bad++;
         if (rk_valid === 1'b1) begin
            if (n < 64) begin got_rk[n] = rk; got_idx[n] = rk_idx; end
            n++;
         end
      end
      rk_req = 1'b0;
      n_cmp++; if (n !== 64) begin n_fail++; $display("FAIL b2b_count got %0d want 64", n); end
      n_cmp++; if (pat_bad !== 0) begin n_fail++; $display("FAIL b2b_valid_pattern got %0d bad cycles want 0", pat_bad); end
      for (int j = 0; j < 64; j++) begin
         n_cmp++;
         if (j < 32) begin
            if (got_idx[j] !== 5'(j) || got_rk[j] !== gold[j]) begin
               n_fail++; $display("FAIL b2b_fwd%0d got %0d/%h want %0d/%h", j, got_idx[j], got_rk[j], j, gold[j]);
            end
         end else begin
            if (got_idx[j] !== 5'(63 - j) || got_rk[j] !== gold[63-j]) begin
               n_fail++; $display("FAIL b2b_rev%0d got %0d/%h want %0d/%h", j, got_idx[j], got_rk[j], 63 - j, gold[63-j]);
            end
         end
      end
   endtask

   task automatic test_second_key;
      int lat, nv, fk, lk, kb;
      compute_gold(ZERO_KEY);
      load_key(ZERO_KEY);
      n_cmp++; if (sched_done !== 1'b0) begin n_fail++; $display("FAIL key2_done_drop got %b want 0", sched_done); end
      wait_done(lat);
      n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL key2_latency got %0d want 32", lat); end
      do_stream(1'b0, 0, nv, fk, lk, kb);
      n_cmp++; if (nv !== 32) begin n_fail++; $display("FAIL key2_count got %0d want 32", nv); end
      for (int j = 0; j < 32; j++) begin
         n_cmp++;
         if (got_idx[j] !== 5'(j) || got_rk[j] !== gold[j]) begin
            n_fail++; $display("FAIL key2_word%0d got %0d/%h want %0d/%h", j, got_idx[j], got_rk[j], j, gold[j]);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_standard();
      test_reverse();
      test_collision();
      test_midstream_key();
      test_reset_expand();
      test_back_to_back();
      test_second_key();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sm4_key_schedule.md
# sm4_key_schedule

Sequential SM4 key-schedule engine. It accepts a 128-bit master key and iterates the key-expansion round once per clock to produce round keys rk0..rk31 into an internal 32x32 store. It then serves those keys to the datapath in forward order (encryption) or reverse order (decryption). It sits between the key-load interface and the round-function datapath, replacing any combinational 32-round unrolling.

## Interface
- No parameters; round count fixed at 32, word width fixed at 32.
- `clk` — in, 1: single clock, rising edge.
- `rst` — in, 1: asynchronous, active-high reset.
- `key_valid` — in, 1: master key offered.
- `key_ready` — out, 1: engine accepts a key (IDLE or READY).
- `mkey` — in, 128: master key; word 0 = `mkey[127:96]`, MSB-first.
- `sched_done` — out, 1: level; round-key store complete and valid.
- `rk_req` — in, 1: start a 32-word round-key stream.
- `rk_dir` — in, 1: sampled with `rk_req`; 0 = forward rk0..rk31, 1 = reverse rk31..rk0.
- `rk_valid` — out, 1: `rk`/`rk_idx` valid this cycle.
- `rk_idx` — out, 5: index of the word on `rk`.
- `rk` — out, 32: round key.

## Operation
- **States:** IDLE, EXPAND, READY, STREAM.
- **IDLE:** `key_ready`=1, `sched_done`=0. `rk_req` is ignored.
- **Key accept:** happens on the edge where `key_valid && key_ready`.
  - K0..K3 load as MK_j ^ FK_j.
  - Round counter i clears to 0; state goes to EXPAND.
  - `sched_done` drops to 0 in the same edge.
- **EXPAND:** one round per cycle.
  - rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i).
  - T' = S-box tau on each byte, then L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - rk_i is written to store[i]; the K window shifts left by one word (new word = rk_i); i increments.
  - After i=31 is written, the next state is READY. `key_ready`=0 throughout EXPAND; `key_valid` is ignored.
- **CK_i:** byte j of CK_i = (4i+j)*7 mod 256, MSB byte first. It comes from a package function or table, not a run-time multiplier.
- **READY:** `sched_done`=1, `key_ready`=1.
  - A new key accepted here restarts EXPAND and discards the old store.
  - `rk_req`=1 (with no key accept the same cycle) latches `rk_dir`, sets pointer p = 0 (fwd) or 31 (dec), and enters STREAM.
  - If `key_valid` and `rk_req` arrive together in READY, the key wins and `rk_req` is dropped.
- **STREAM:** `rk_valid`=1 for exactly 32 consecutive cycles.
  - Each cycle outputs `rk`=store[p], `rk_idx`=p; p then steps +1 (fwd) or -1 (dec).
  - After the 32nd word the state returns to READY and `sched_done` stays 1.
  - `key_ready`=0 and `rk_req` is ignored during STREAM.
- **Reset values, any state:** state=IDLE, `key_ready`=0 while `rst` is asserted and 1 from the first cycle after release. `sched_done`=0, `rk_valid`=0, `rk`=0, `rk_idx`=0. Store contents are don't-care, because `sched_done`=0 invalidates them.
- **Reset mid-EXPAND or mid-STREAM:** aborts immediately. No partial `rk_valid` after reset release.

## Timing
- Key accepted at edge t:
  - rk0 is in the store after edge t+1; rk31 after edge t+32.
  - `sched_done`=1 from edge t+32 onward. Key-to-done latency is 32 cycles.
- `rk_req` sampled high at edge s:
  - First word is registered at edge s+1 (`rk_valid` high in cycle s+1..s+32).
  - Last word is at s+32; READY is entered at edge s+33.
  - Back-to-back: `rk_req` may be asserted in cycle s+33, and the next stream starts at s+34.
- `rk`, `rk_idx`, `rk_valid`, `sched_done`, `key_ready` are all registered outputs. No combinational input-to-output path.
- Counter i and pointer p are 5-bit. A wrap of p after the final word must not produce an extra `rk_valid`.

## Structure
- **Package `sm4_pkg`:** FK[0:3] constants, the 256-entry S-box, a CK_i function/table, the state enum, and the `rot_l32` helper.
- **Sub-module `sm4_key_round`:** purely combinational; inputs k0..k3 and ck, output rk. Instantiated once and reused every EXPAND cycle.
- Round-key store is a 32x32 flop array with one write port (EXPAND) and one read port (STREAM).

## Test plan
- **Standard vector:** MK=0123456789ABCDEFFEDCBA9876543210, forward stream → rk_idx 0 `rk`=F12186F9, idx 1 41662B61, idx 31 9124A012. `sched_done` asserts exactly 32 cycles after key accept.
- **Reverse stream:** same key, `rk_dir`=1 → first word idx 31 9124A012, last word idx 0 F12186F9. `rk_valid` high for exactly 32 cycles.
- **Collision and mid-stream key:** `key_valid` and `rk_req` together in READY → re-expansion, no stream. `key_valid` during STREAM → `key_ready`=0, stream completes unchanged.
- **Reset during EXPAND** (cycle 10) → all outputs 0, `sched_done`=0. Re-run the vector → correct rk0/rk31.
- **Back-to-back streams:** fwd then dec with minimum gap → 64 valid words, no gap beyond one READY cycle, no duplicate or extra word.
- **Second key after READY:** MK=all-zero → new store fully replaces the old. Compare all 32 words to the golden model.
